// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and modular-arithmetic helpers for the
// NTT datapath.
//   Q, DATA_WIDTH   modulus and coefficient width (Q < 2^(DATA_WIDTH-1))
//   MO_MUL_LATENCY  latency of the modular multiplier selected by MUL_TYPE
//   MUL_ONE         twiddle that makes the multiplier return its operand
//   bfly_mode_e     butterfly flavour (CT forward / GS inverse)
//   mod_add/mod_sub/mod_norm/mod_half/mod_mul  arithmetic on [0,Q-1]
package ntt_pkg;

    localparam int Q          = 3329;
    localparam int DATA_WIDTH = 13;

    typedef logic [DATA_WIDTH-1:0] coef_t;
    typedef logic [DATA_WIDTH:0]   ext_t;

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam coef_t Q_C     = coef_t'(Q);
    localparam ext_t  Q_E     = ext_t'(Q);
    localparam logic [PROD_WIDTH-1:0] Q_P = PROD_WIDTH'(Q);

    // Multiplier flavours and their reduction pipeline depths. Every flavour
    // spends one cycle on the full product before its reduction stages.
    localparam int MUL_KRED = 0;
    localparam int MUL_KLMM = 1;
    localparam int MUL_XLMM = 2;

    localparam int MUL_PROD_STAGES = 1;
    localparam int KRED_STAGES     = 1;
    localparam int KLMM_STAGES     = 2;
    localparam int XLMM_STAGES     = 3;

`ifdef MUL_TYPE_KRED
    localparam int MUL_TYPE_SEL = MUL_KRED;
`elsif MUL_TYPE_XLMM
    localparam int MUL_TYPE_SEL = MUL_XLMM;
`else
    localparam int MUL_TYPE_SEL = MUL_KLMM;
`endif

    function automatic int mul_latency(input int mul_type);
        case (mul_type)
            MUL_KRED: return MUL_PROD_STAGES + KRED_STAGES;
            MUL_XLMM: return MUL_PROD_STAGES + XLMM_STAGES;
            default:  return MUL_PROD_STAGES + KLMM_STAGES;
        endcase
    endfunction

    localparam int MO_MUL_LATENCY = mul_latency(MUL_TYPE_SEL);

    // The reduction used here carries no constant factor, so the identity
    // twiddle is plain 1.
    localparam coef_t MUL_ONE = coef_t'(1);

    typedef enum logic {
        BFLY_CT = 1'b0,
        BFLY_GS = 1'b1
    } bfly_mode_e;

    // (a + b) mod Q for a, b in [0,Q]; one conditional subtraction suffices.
    function automatic coef_t mod_add(input coef_t a, input coef_t b);
        ext_t sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= Q_E) sum = sum - Q_E;
        return coef_t'(sum);
    endfunction

    // (a - b) mod Q for a, b in [0,Q]; one conditional addition suffices.
    function automatic coef_t mod_sub(input coef_t a, input coef_t b);
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff < 0) diff = diff + $signed(Q_E);
        return coef_t'(diff);
    endfunction

    // Fold the multiplier's legal output Q back onto 0.
    function automatic coef_t mod_norm(input coef_t v);
        return (v == Q_C) ? '0 : v;
    endfunction

    // v * 2^-1 mod Q for odd Q: odd values borrow one Q so the shift is exact.
    function automatic coef_t mod_half(input coef_t v);
        ext_t t;
        t = v[0] ? ({1'b0, v} + Q_E) : {1'b0, v};
        return coef_t'(t >> 1);
    endfunction

    function automatic coef_t mod_mul(input coef_t x, input coef_t w);
        logic [PROD_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, w};
        return coef_t'(prod % Q_P);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: fixed-depth shift register carrying a data word and its
// valid bit. Only the valid bits are reset; data simply follows.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_data    word entering the line
//   out_valid, out_data  same word DEPTH cycles later
module ntt_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // NOTE: sequential state is updated with <= so every stage samples the
    // value its neighbour held before this edge; = would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    // NOTE: the data array has no reset on purpose; the valid bits alone
    // decide whether a word means anything, and resetting wide storage only
    // costs routing.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: radix-2 NTT/INTT butterfly sharing one modular
// multiplier between Cooley-Tukey (forward) and Gentleman-Sande (inverse)
// modes. Both modes take LATENCY = MUL_LAT+3 cycles from input to output and
// accept one beat per cycle; a mode change waits for the pipe to drain.
//   CT: x = a + b*w,  y = a - b*w        GS: x = a + b,  y = (a - b)*w
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (transfer when both high)
//   in_mode                 0 = CT, 1 = GS
//   in_a, in_b, in_w        coefficients in [0,Q-1], twiddle
//   out_valid, out_x, out_y result beat (no backpressure); data holds
//   busy                    one or more beats in flight
// Build option: define BFLY_HALF_EN to halve both GS outputs mod Q in the
// final stage (folds the per-layer INTT 1/2 scaling).
module ntt_butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0]      in_w,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  busy
);

    localparam int MUL_LAT = MO_MUL_LATENCY;
    localparam int LATENCY = MUL_LAT + 3;
    localparam int CNT_W   = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);

    if (WIDTH != DATA_WIDTH) begin : g_bad_width
        $error("ntt_butterfly_pipe: WIDTH must equal DATA_WIDTH");
    end
    if (Q >= (1 << (DATA_WIDTH - 1))) begin : g_bad_q
        $error("ntt_butterfly_pipe: Q must be below 2^(DATA_WIDTH-1)");
    end

    // ---------------- flow control ----------------
    bfly_mode_e       req_mode;
    bfly_mode_e       cur_mode;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign req_mode = bfly_mode_e'(in_mode);
    assign in_ready = (cnt == '0) || (req_mode == cur_mode);
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0);

    // cnt covers a beat from its accepting edge through its out_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({accept, out_valid})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Only one mode is ever in flight, so cur_mode steers every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode <= BFLY_CT;
        end else if (accept && (cnt == '0)) begin
            cur_mode <= req_mode;
        end
    end

    // ---------------- S0: input register ----------------
    logic  s0_valid;
    coef_t s0_a, s0_b, s0_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s0_valid <= 1'b0;
        else        s0_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s0_a <= in_a;
            s0_b <= in_b;
            s0_w <= coef_t'(in_w);
        end
    end

    // ---------------- GS add/sub stage ----------------
    coef_t as_d, as_w;

    always_ff @(posedge clk) begin
        as_d <= mod_sub(s0_a, s0_b);
        as_w <= s0_w;
    end

    // ---------------- shared multiplier input ----------------
    // CT feeds the multiplier straight from S0; GS one stage later with d.
    // GS's sum enters the alignment line from S0 already reduced, which is
    // equivalent to registering it and delaying it MUL_LAT cycles.
    coef_t mul_x, mul_w, line_in;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mul_x   = s0_b;
        mul_w   = s0_w;
        line_in = s0_a;
        if (cur_mode == BFLY_GS) begin
            mul_x   = as_d;
            mul_w   = as_w;
            line_in = mod_add(s0_a, s0_b);
        end
    end

    // ---------------- modular multiplier (MUL_LAT cycles) ----------------
    coef_t mul_pipe [MUL_LAT];
    coef_t mul_out;

    always_ff @(posedge clk) begin
        mul_pipe[0] <= mod_mul(mul_x, mul_w);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    assign mul_out = mul_pipe[MUL_LAT-1];

    // ---------------- alignment ----------------
    // CT product appears one cycle before GS's; the balancing register lines
    // the two modes up on the same final stage.
    coef_t bal_m;

    always_ff @(posedge clk) bal_m <= mul_out;

    logic  line_valid;
    coef_t line_data;

    ntt_delay_line #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(MUL_LAT + 1)
    ) u_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s0_valid),
        .in_data  (line_in),
        .out_valid(line_valid),
        .out_data (line_data)
    );

    // ---------------- final stage ----------------
    coef_t fin_x, fin_y;

    always_comb begin
        fin_x = mod_add(line_data, bal_m);
        fin_y = mod_sub(line_data, bal_m);
        if (cur_mode == BFLY_GS) begin
`ifdef BFLY_HALF_EN
            fin_x = mod_half(line_data);
            fin_y = mod_half(mod_norm(mul_out));
`else
            fin_x = line_data;
            fin_y = mod_norm(mul_out);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= line_valid;
            if (line_valid) begin
                out_x <= fin_x;
                out_y <= fin_y;
            end
        end
    end

    // ---------------- in-flight counter sanity ----------------
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_valid && !accept && (cnt == '0)));
    a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && !out_valid && (cnt == CNT_MAX)));

endmodule
